instr_encoder_loader: RTL and testbench

- Encoder-side counterpart of the decode stage: takes opcode plus operand fields, packs them into 32-bit instruction words in the same format the decoder splits apart, and writes them sequentially into instruction memory.
- Used by the boot/test loader to fill the Harvard instruction store before the core is released.
- Small FIFO between the encode stage and the memory write port absorbs memory back-pressure.

---
 rtl/instr_encoder_loader.sv | 146 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs opcode/operand tuples into 32-bit words and streams them into instruction memory; INSTR_ENC_CHECKSUM_EN appends an XOR checksum word
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd2,
  input  logic [4:0]        in_rd1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rs1,
  input  logic [15:0]       in_imm,
  input  logic [7:0]        in_addr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic [5:0]        err_op,
  output logic              err_ovf
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CSUM, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0] cnt_q, occ;
  logic [31:0] stg_q, csum_q, enc;
  logic stg_v_q, legal, hs, empty, pop, wr_done, last;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0] count_q;
  logic err_illegal_q, err_ovf_q;
  logic [5:0] err_op_q;
  assign legal = in_op < 6'd18;
  assign enc = {in_op, (in_op == 6'd0) ? {in_rd2, 5'd0, in_imm} :
                       (in_op == 6'd1) ? {in_rd2, 16'd0, in_rs2} :
                       (in_op == 6'd2) ? {in_rd2, 13'd0, in_addr} :
                       (in_op == 6'd3) ? {in_addr, 13'd0, in_rs2} :
                                         {in_rd2, in_rd1, 6'd0, in_rs2, in_rs1}};
  // the staged word already owns a FIFO slot, so it counts toward occupancy
  assign occ = cnt_q + (PW+1)'(stg_v_q);
  assign empty = cnt_q == '0;
  assign hs = in_valid && in_ready;
  // after overflow the FIFO keeps draining but nothing reaches memory
  assign pop = state_q != IDLE && !empty && (err_ovf_q || imem_ready);
  assign wr_done = imem_we && imem_ready;
  assign last = ptr_q == '1;
  assign imem_addr = ptr_q;
  assign count = count_q;
  assign err_illegal = err_illegal_q;
  assign err_op = err_op_q;
  assign err_ovf = err_ovf_q;
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (flush) state_d = DRAIN;
`ifdef INSTR_ENC_CHECKSUM_EN
      DRAIN: if (empty && !stg_v_q) state_d = CSUM;
      CSUM: if (err_ovf_q || imem_ready) state_d = DONE;
`else
      DRAIN: if (empty && !stg_v_q) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded from state and FIFO status
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    in_ready = state_q == LOAD && occ != FULL && !err_ovf_q;
    imem_we = (state_q == CSUM) ? !err_ovf_q : (busy && !empty && !err_ovf_q);
    imem_wdata = !imem_we ? '0 : (state_q == CSUM) ? csum_q : mem_q[rd_q];
  end
  // encode stage, FIFO, write pointer and session status
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_v_q <= 1'b0;
      stg_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      count_q <= '0;
      err_illegal_q <= 1'b0;
      err_op_q <= '0;
      err_ovf_q <= 1'b0;
    end else if (state_q == IDLE) begin
      stg_v_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      if (start) begin
        ptr_q <= base_addr;
        count_q <= '0;
        err_illegal_q <= 1'b0;
        err_op_q <= '0;
        err_ovf_q <= 1'b0;
      end
    end else begin
      stg_v_q <= hs && legal;
      if (hs && legal) stg_q <= enc;
      if (hs && !legal) begin
        err_illegal_q <= 1'b1;
        if (!err_illegal_q) err_op_q <= in_op;
      end
      if (stg_v_q) begin
        mem_q[wr_q] <= stg_q;
        wr_q <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(stg_v_q) - (PW+1)'(pop);
      if (wr_done) begin
        count_q <= count_q + (ADDR_W+1)'(1);
        if (last) err_ovf_q <= 1'b1;
        else ptr_q <= ptr_q + ADDR_W'(1);
      end
    end
  end
`ifdef INSTR_ENC_CHECKSUM_EN
  // running XOR of every program word written this session
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) csum_q <= '0;
    else if (wr_done && state_q != CSUM) csum_q <= csum_q ^ imem_wdata;
  end
`else
  assign csum_q = '0;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, back-pressure, illegal ops, overflow and mid-session reset
module tb_instr_encoder_loader;
  logic clk = 0;
  logic rst, start, flush, in_valid, imem_ready, sel;
  logic [7:0] base_addr, in_addr;
  logic [5:0] in_op;
  logic [4:0] in_rd2, in_rd1, in_rs2, in_rs1;
  logic [15:0] in_imm;
  logic rdy8, we8, busy8, done8, ei8, eo8, rdy4, we4, busy4, done4, ei4, eo4;
  logic [7:0] addr8;
  logic [3:0] addr4;
  logic [31:0] wd8, wd4;
  logic [8:0] cnt8;
  logic [4:0] cnt4;
  logic [5:0] eop8, eop4;
  logic rdy, we, busy, done, ei, eo;
  logic [7:0] addr;
  logic [31:0] wd;
  logic [8:0] cnt;
  logic [5:0] eop;
  logic [39:0] wq[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(4)) u8 (
    .clk(clk), .rst(rst), .start(start && !sel), .base_addr(base_addr), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op), .in_rd2(in_rd2), .in_rd1(in_rd1),
    .in_rs2(in_rs2), .in_rs1(in_rs1), .in_imm(in_imm), .in_addr(in_addr),
    .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8), .imem_ready(imem_ready),
    .busy(busy8), .done(done8), .count(cnt8), .err_illegal(ei8), .err_op(eop8), .err_ovf(eo8));

  instr_encoder_loader #(.ADDR_W(4), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start && sel), .base_addr(base_addr[3:0]), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy4), .in_op(in_op), .in_rd2(in_rd2), .in_rd1(in_rd1),
    .in_rs2(in_rs2), .in_rs1(in_rs1), .in_imm(in_imm), .in_addr(in_addr),
    .imem_we(we4), .imem_addr(addr4), .imem_wdata(wd4), .imem_ready(imem_ready),
    .busy(busy4), .done(done4), .count(cnt4), .err_illegal(ei4), .err_op(eop4), .err_ovf(eo4));

  assign rdy  = sel ? rdy4 : rdy8;
  assign we   = sel ? we4 : we8;
  assign addr = sel ? {4'd0, addr4} : addr8;
  assign wd   = sel ? wd4 : wd8;
  assign busy = sel ? busy4 : busy8;
  assign done = sel ? done4 : done8;
  assign cnt  = sel ? {4'd0, cnt4} : cnt8;
  assign ei   = sel ? ei4 : ei8;
  assign eop  = sel ? eop4 : eop8;
  assign eo   = sel ? eo4 : eo8;

  always @(negedge clk) if (we && imem_ready) wq.push_back({addr, wd});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input int i, input logic [7:0] a, input logic [31:0] d);
    logic [39:0] e;
    e = (i < wq.size()) ? wq[i] : 40'hx;
    chk($sformatf("write%0d", i), e, {a, d});
  endtask

  task automatic do_start(input logic [7:0] b);
    start = 1;
    base_addr = b;
    tick();
    start = 0;
  endtask

  task automatic do_flush;
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] r2, input logic [4:0] r1,
                      input logic [4:0] s2, input logic [4:0] s1, input logic [15:0] imm,
                      input logic [7:0] a);
    int n = 0;
    in_op = op; in_rd2 = r2; in_rd1 = r1; in_rs2 = s2; in_rs1 = s1; in_imm = imm; in_addr = a;
    in_valid = 1;
    while (!rdy && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", rdy, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("done_pulse", done, 1);
    tick();
    chk("done_drop", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1; start = 0; flush = 0; in_valid = 0; imem_ready = 1; sel = 0;
    base_addr = 0; in_addr = 0; in_op = 0; in_rd2 = 0; in_rd1 = 0; in_rs2 = 0; in_rs1 = 0; in_imm = 0;
    tick();
    tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_count", cnt, 0);
    chk("rst_eill", ei, 0);
    chk("rst_eop", eop, 0);
    chk("rst_eovf", eo, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wd, 0);

    wq.delete();
    do_start(8'h10);
    chk("t1_busy", busy, 1);
    send(6'd4, 5'd3, 5'd4, 5'd5, 5'd6, 16'h0, 8'h0);
    chk("t1_lat1", we, 0);
    tick();
    chk("t1_lat2", we, 1);
    chk("t1_addr", addr, 8'h10);
    chk("t1_data", wd, 32'h106400A6);
    do_flush();
    wait_done();
    chk("t1_nwr", wq.size(), 1);
    chk_w(0, 8'h10, 32'h106400A6);
    chk("t1_count", cnt, 1);

    wq.delete();
    do_start(8'h20);
    chk("t2_count_clr", cnt, 0);
    send(6'd0, 5'd1, 5'd0, 5'd0, 5'd0, 16'hBEEF, 8'h0);
    send(6'd3, 5'd0, 5'd0, 5'd7, 5'd0, 16'h0, 8'hFF);
    do_flush();
    wait_done();
    chk("t2_nwr", wq.size(), 2);
    chk_w(0, 8'h20, 32'h0020BEEF);
    chk_w(1, 8'h21, 32'h0FFC0007);
    chk("t2_count", cnt, 2);

    wq.delete();
    do_start(8'h30);
    send(6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 8'h55);
    send(6'h12, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 8'h55);
    send(6'd1, 5'd2, 5'd0, 5'd9, 5'd0, 16'h0, 8'h0);
    do_flush();
    wait_done();
    chk("t3_nwr", wq.size(), 1);
    chk_w(0, 8'h30, 32'h04400009);
    chk("t3_eill", ei, 1);
    chk("t3_eop", eop, 6'h3F);
    chk("t3_count", cnt, 1);
    chk("t3_eovf", eo, 0);

    wq.delete();
    do_start(8'h40);
    chk("t4_eill_clr", ei, 0);
    imem_ready = 0;
    k = 0;
    in_valid = 1;
    for (int c = 0; c < 6; c++) begin
      logic acc;
      in_op = 6'd5; in_rd2 = 0; in_rd1 = 0; in_rs2 = 0; in_rs1 = 5'(k);
      acc = rdy;
      tick();
      if (acc) k++;
    end
    chk("t4_accepts", k, 4);
    chk("t4_ready_low", rdy, 0);
    chk("t4_stall_we", we, 1);
    chk("t4_stall_addr", addr, 8'h40);
    chk("t4_stall_nwr", wq.size(), 0);
    imem_ready = 1;
    for (int c = 0; c < 30 && k < 6; c++) begin
      logic acc;
      in_rs1 = 5'(k);
      acc = rdy;
      tick();
      if (acc) k++;
    end
    in_valid = 0;
    chk("t4_accepts_all", k, 6);
    do_flush();
    wait_done();
    chk("t4_nwr", wq.size(), 6);
    for (int i = 0; i < 6; i++) chk_w(i, 8'h40 + 8'(i), 32'h14000000 + 32'(i));
    chk("t4_count", cnt, 6);

    wq.delete();
    sel = 1;
    do_start(8'h0E);
    send(6'd4, 5'd0, 5'd0, 5'd0, 5'd1, 16'h0, 8'h0);
    send(6'd4, 5'd0, 5'd0, 5'd0, 5'd2, 16'h0, 8'h0);
    send(6'd4, 5'd0, 5'd0, 5'd0, 5'd3, 16'h0, 8'h0);
    do_flush();
    wait_done();
    chk("t5_nwr", wq.size(), 2);
    chk_w(0, 8'h0E, 32'h10000001);
    chk_w(1, 8'h0F, 32'h10000002);
    chk("t5_eovf", eo, 1);
    chk("t5_count", cnt, 2);
    sel = 0;

    wq.delete();
    do_start(8'h50);
    imem_ready = 0;
    send(6'd4, 5'd0, 5'd0, 5'd0, 5'd1, 16'h0, 8'h0);
    send(6'd4, 5'd0, 5'd0, 5'd0, 5'd2, 16'h0, 8'h0);
    send(6'd4, 5'd0, 5'd0, 5'd0, 5'd3, 16'h0, 8'h0);
    tick();
    chk("t6_pending", we, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_we", we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_count", cnt, 0);
    imem_ready = 1;
    do_start(8'h60);
    send(6'd4, 5'd0, 5'd0, 5'd0, 5'd7, 16'h0, 8'h0);
    do_flush();
    wait_done();
    chk("t6_nwr", wq.size(), 1);
    chk_w(0, 8'h60, 32'h10000007);
    chk("t6_count_new", cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
